character_anim_ctrl: RTL
========================

// Module: character_anim_ctrl
// PURPOSE
//  Sequences the character skin ROM: picks the 3-bit skin code (IDLE/PREP/JUMP/LEFT/RIGHT) each video frame
//  from the player-motion flags. Sits between player physics/control and the skin ROM; output drives its skin select.
//  Changes the code only on frame boundaries, so the sprite never switches skin mid-frame.
//  Applies a minimum hold time and a landing squash so a flag glitch does not flicker the skin.
// PARAMETERS
//  HOLD_FRAMES  4   min frames LEFT/RIGHT is held after the move input drops
//  LAND_FRAMES  6   frames PREP (curled) is shown after touchdown
//  WALK_FRAMES  8   half-period of walk stepping (only with CHAR_WALK_ANIM_EN)
// PORTS
//  clk            in   1  system clock (pixel clock domain)
//  rst            in   1  synchronous, active-high reset
//  frame_tick     in   1  one-clk pulse per frame (vblank start)
//  on_ground      in   1  character is standing on a platform
//  jump_charging  in   1  jump key held; charge accumulating
//  move_left      in   1  left key held
//  move_right     in   1  right key held
//  skin           out  3  skin code to the skin ROM (character_skin_t)
//  skin_changed   out  1  one-clk pulse when skin takes a new value
// BEHAVIOUR
//  - Reset: skin=IDLE(3'd0), skin_changed=0, all frame counters=0, state=IDLE; applies mid-operation at the next edge.
//  - Inputs are sampled only in the cycle where frame_tick=1; skin/skin_changed update on the following edge (latency 1 clk).
//  - No frame_tick: state, skin and counters hold; skin_changed=0.
//  - States = codes: IDLE 0, PREP 1, JUMP 2, LEFT 3, RIGHT 4; skin is the registered state (or the walk override).
//  - Priority at each tick, highest first:
//    1 !on_ground -> JUMP (from any state, overrides the hold and land timers).
//    2 JUMP & on_ground -> PREP; land counter loaded with LAND_FRAMES-1 (landing squash).
//    3 PREP with land counter>0 -> stay, decrement; at 0 fall through to 4-6.
//    4 on_ground & jump_charging -> PREP (charge pose). Left/right are ignored while charging.
//    5 move_left XOR move_right -> LEFT/RIGHT; hold counter reloaded with HOLD_FRAMES-1.
//    6 no valid move: LEFT/RIGHT stay while hold counter>0 (decrement), then -> IDLE.
//      PREP (charge released, land done) -> IDLE.
//  - move_left & move_right both high = no move (rule 6 applies).
//  - Direction reversal LEFT<->RIGHT is immediate (rule 5), with no hold.
//  - All counters saturate at 0 and never wrap; width = $clog2(max param + 1).
//  - skin_changed=1 for exactly one clk when the new skin != old skin; a tick with no change leaves it 0.
//  - Out-of-range codes 5..7 are never produced.
// CONFIGURATION
//  CHAR_WALK_ANIM_EN defined: while in LEFT/RIGHT with the move input active, a walk counter toggles a step bit
//    every WALK_FRAMES ticks. While step=1, skin outputs IDLE instead of LEFT/RIGHT (2-pose walk cycle).
//    step clears when LEFT/RIGHT is entered or left. skin_changed also pulses on each step toggle.
//  Undefined: no walk counter or step logic; LEFT/RIGHT shown steadily.
// STRUCTURE
//  - character_pkg (shared): character_skin_t enum {MICRO_IDLE..MICRO_RIGHT}, SKIN_W=3.
//    The skin ROM and this block both import it; the enum is removed from the ROM module.
//  - One sub-module, character_frame_timer: loadable, saturating down-counter.
//    Ports: clk, rst, tick, load, load_val, zero. Instanced for hold, land and (optionally) walk.
//  - Top: 1 FSM (always_ff state + always_comb next), registered outputs.
// TESTING
//  1 Reset held 3 clks with ticks and all flags high -> skin=0, skin_changed=0 throughout.
//  2 on_ground=1, move_left=1, tick -> skin=3 one clk after tick, skin_changed 1 clk.
//    Drop move_left -> skin stays 3 for 3 more ticks, becomes 0 on the 4th (HOLD_FRAMES=4).
//  3 Charge: on_ground=1, jump_charging=1, tick -> skin=1; left=1 also asserted -> still 1.
//    on_ground=0 -> 2 at next tick.
//  4 Landing: in JUMP, on_ground=1 with no inputs -> skin=1 for 6 ticks, then 0. on_ground=0 mid-squash -> 2 immediately.
//  5 Simultaneous left+right from IDLE -> skin stays 0. Right while in LEFT -> 4 at the next tick, no hold.
//  6 Flags toggled between ticks -> no skin change. Under CHAR_WALK_ANIM_EN, hold right: 4,0,4 alternating every 8 ticks.

Source files
------------

// File: rtl/character_pkg.sv
// Shared skin codes for the character animation controller and the skin ROM.
// Latency: none (types and constants only).
// Backpressure: none.
package character_pkg;

   localparam int SKIN_W = 3;

   // Codes match the skin ROM address map; 5..7 are unused.
   typedef enum logic [SKIN_W-1:0] {
      MICRO_IDLE  = 3'd0,
      MICRO_PREP  = 3'd1,
      MICRO_JUMP  = 3'd2,
      MICRO_LEFT  = 3'd3,
      MICRO_RIGHT = 3'd4
   } character_skin_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic is_side(input character_skin_t s);
      return (s == MICRO_LEFT) || (s == MICRO_RIGHT);
   endfunction

endpackage

// File: rtl/character_frame_timer.sv
// Loadable down-counter of frames that saturates at zero; zero flags expiry.
// Latency: load/decrement visible one clk later; zero is combinational from the count.
// Backpressure: none; load wins over tick.
module character_frame_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // Reload, or count down one step per tick without wrapping below zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/character_anim_ctrl.sv
// Picks the skin code per video frame from motion flags, with move hold, landing squash and optional walk cycle (CHAR_WALK_ANIM_EN).
// Latency: flags sampled on frame_tick, skin/skin_changed registered one clk later.
// Backpressure: none; outputs hold between frame ticks.
module character_anim_ctrl
   import character_pkg::*;
#(
   parameter int HOLD_FRAMES = 4,
   parameter int LAND_FRAMES = 6,
   parameter int WALK_FRAMES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              on_ground,
   input  logic              jump_charging,
   input  logic              move_left,
   input  logic              move_right,
   output logic [SKIN_W-1:0] skin,
   output logic              skin_changed
);

   localparam int CNT_W = $clog2(max3(HOLD_FRAMES, LAND_FRAMES, WALK_FRAMES) + 1);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [CNT_W-1:0] LAND_LD = CNT_W'(LAND_FRAMES - 1);

   character_skin_t   state_q, state_d;
   logic [SKIN_W-1:0] skin_q, skin_d;
   logic              changed_q;
   logic              hold_load, hold_dec, hold_zero;
   logic              land_load, land_dec, land_zero;
   logic              move_vld;

   assign move_vld = move_left ^ move_right;

   character_frame_timer #(.W(CNT_W)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .tick     (hold_dec),
      .load     (hold_load),
      .load_val (HOLD_LD),
      .zero     (hold_zero)
   );

   character_frame_timer #(.W(CNT_W)) u_land (
      .clk      (clk),
      .rst      (rst),
      .tick     (land_dec),
      .load     (land_load),
      .load_val (LAND_LD),
      .zero     (land_zero)
   );

   // Next pose, evaluated only on a frame tick in strict priority order.
   always_comb begin
      state_d   = state_q;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      land_load = 1'b0;
      land_dec  = 1'b0;
      if (frame_tick) begin
         if (!on_ground) begin
            state_d = MICRO_JUMP;
         end else if (state_q == MICRO_JUMP) begin
            state_d   = MICRO_PREP;
            land_load = 1'b1;
         end else if ((state_q == MICRO_PREP) && !land_zero) begin
            land_dec = 1'b1;
         end else if (jump_charging) begin
            state_d = MICRO_PREP;
         end else if (move_vld) begin
            state_d   = move_left ? MICRO_LEFT : MICRO_RIGHT;
            hold_load = 1'b1;
         end else if (is_side(state_q) && !hold_zero) begin
            hold_dec = 1'b1;
         end else begin
            state_d = MICRO_IDLE;
         end
      end
   end

`ifdef CHAR_WALK_ANIM_EN
   localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_FRAMES - 1);

   logic step_q, step_d;
   logic walk_load, walk_dec, walk_zero;

   character_frame_timer #(.W(CNT_W)) u_walk (
      .clk      (clk),
      .rst      (rst),
      .tick     (walk_dec),
      .load     (walk_load),
      .load_val (WALK_LD),
      .zero     (walk_zero)
   );

   // Walk step: restart on entering a side pose, toggle while the key stays held, clear on leaving.
   always_comb begin
      step_d    = step_q;
      walk_load = 1'b0;
      walk_dec  = 1'b0;
      if (frame_tick) begin
         if (!is_side(state_d)) begin
            step_d = 1'b0;
         end else if (state_d != state_q) begin
            step_d    = 1'b0;
            walk_load = 1'b1;
         end else if (hold_load) begin
            if (walk_zero) begin
               step_d    = ~step_q;
               walk_load = 1'b1;
            end else begin
               walk_dec = 1'b1;
            end
         end
      end
      skin_d = (step_d && is_side(state_d)) ? MICRO_IDLE : state_d;
   end

   // Walk step register.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step_d;
      end
   end
`else
   // Side poses are shown steadily.
   always_comb begin
      skin_d = state_d;
   end
`endif

   // Pose, skin code and change pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MICRO_IDLE;
         skin_q    <= MICRO_IDLE;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         skin_q    <= skin_d;
         changed_q <= frame_tick && (skin_d != skin_q);
      end
   end

   assign skin         = skin_q;
   assign skin_changed = changed_q;

endmodule
